// File: rtl/branch_pkg.sv
// Shared definitions for the branch-condition unit: op encodings and the
// reserved-encoding check.
package branch_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLEZ = 3'd2,
      BR_BGTZ = 3'd3,
      BR_BLTZ = 3'd4,
      BR_BGEZ = 3'd5,
      BR_RSV6 = 3'd6,
      BR_RSV7 = 3'd7
   } br_op_e;

   function automatic logic is_reserved(input logic [OP_W-1:0] op);
      logic rsv;
      case (op)
         BR_RSV6, BR_RSV7: rsv = 1'b1;
         default:          rsv = 1'b0;
      endcase
      return rsv;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational evaluation of the six compare-branch conditions.
// Sign tests look at rs_data only: MSB for negative, all-zero for zero.
module branch_cond
   import branch_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             cond,
   output logic             reserved
);

   logic rs_neg_s;
   logic rs_zero_s;
   logic rs_eq_rt_s;

   assign rs_neg_s   = rs_data[WIDTH-1];
   assign rs_zero_s  = (rs_data == {WIDTH{1'b0}});
   assign rs_eq_rt_s = (rs_data == rt_data);

   // condition select; reserved encodings never branch
   always_comb begin
      cond     = 1'b0;
      reserved = is_reserved(op);
      case (op)
         BR_BEQ:  cond = rs_eq_rt_s;
         BR_BNE:  cond = !rs_eq_rt_s;
         BR_BLEZ: cond = rs_neg_s || rs_zero_s;
         BR_BGTZ: cond = !rs_neg_s && !rs_zero_s;
         BR_BLTZ: cond = rs_neg_s;
         BR_BGEZ: cond = !rs_neg_s;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cmp.sv
// Registered branch decision with stall/flush control and saturating
// branch/taken statistics counters.
module branch_cmp
   import branch_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             stall,
   input  logic             flush,
   input  logic             clr_cnt,
   output logic             out_valid,
   output logic             taken,
   output logic             illegal,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             cond_s;
   logic             reserved_s;
   logic             capture_s;
   logic             valid_q, valid_d;
   logic             taken_q, taken_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   branch_cond #(
      .WIDTH(WIDTH)
   ) u_cond (
      .op       (op),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .cond     (cond_s),
      .reserved (reserved_s)
   );

   assign capture_s = in_valid && !stall && !flush;

   // result register next state: flush beats stall beats capture
   always_comb begin
      valid_d   = valid_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;
      if (flush) begin
         valid_d   = 1'b0;
         taken_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (stall) begin
         valid_d   = valid_q;
         taken_d   = taken_q;
         illegal_d = illegal_q;
      end else if (in_valid) begin
         valid_d   = 1'b1;
         taken_d   = cond_s && !reserved_s;
         illegal_d = reserved_s;
      end else begin
         valid_d   = 1'b0;
         taken_d   = 1'b0;
         illegal_d = 1'b0;
      end
   end

   // counters: clear overrides increment and is honoured under stall
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      if (clr_cnt) begin
         branch_cnt_d = {CNT_W{1'b0}};
         taken_cnt_d  = {CNT_W{1'b0}};
      end else if (capture_s && !reserved_s) begin
         if (branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
         end else begin
            branch_cnt_d = branch_cnt_q;
         end
         if (cond_s && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
         end else begin
            taken_cnt_d = taken_cnt_q;
         end
      end else begin
         branch_cnt_d = branch_cnt_q;
         taken_cnt_d  = taken_cnt_q;
      end
   end

   // state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         taken_q      <= 1'b0;
         illegal_q    <= 1'b0;
         branch_cnt_q <= {CNT_W{1'b0}};
         taken_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         valid_q      <= valid_d;
         taken_q      <= taken_d;
         illegal_q    <= illegal_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign taken      = taken_q;
   assign illegal    = illegal_q;
   assign branch_cnt = branch_cnt_q;
   assign taken_cnt  = taken_cnt_q;

endmodule

// File: doc/branch_cmp.md
# branch_cmp

Parametrised, registered branch-condition unit for the pipelined MIPS core. Evaluates all six compare-branch conditions (beq, bne, blez, bgtz, bltz, bgez) on two operands, registers the decision with stall/flush control, and keeps saturating branch/taken counters for performance readout. Sits at the end of the decode stage; its registered `taken` feeds next-cycle PC selection.

## Interface

Parameters:
- `WIDTH`, 32, operand width in bits (≥2).
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a branch op is presented this cycle.
- `op`  in  3  condition select (encodings under Operation).
- `rs_data`  in  WIDTH  first operand, two's complement.
- `rt_data`  in  WIDTH  second operand (used only by beq/bne).
- `stall`  in  1  hold all registered state.
- `flush`  in  1  kill the captured result.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `out_valid`  out  1  registered result is valid.
- `taken`  out  1  registered branch decision.
- `illegal`  out  1  registered; captured op was a reserved encoding.
- `branch_cnt`  out  CNT_W  count of legal branches captured.
- `taken_cnt`  out  CNT_W  count of taken branches captured.

## Operation

- Op encodings: 0 beq (rs==rt), 1 bne (rs!=rt), 2 blez (rs≤0), 3 bgtz (rs>0), 4 bltz (rs<0), 5 bgez (rs≥0); 6, 7 reserved.
- Sign tests use only `rs_data`: negative = MSB set; zero = all bits clear. No subtraction; no overflow cases.
- Reserved op with `in_valid`: capture `out_valid`=1, `taken`=0, `illegal`=1; counters unchanged.
- Capture condition: `in_valid` & !`stall` & !`flush`. On capture: `out_valid`←1, `taken`←cond, `illegal`←reserved.
- No capture and no stall and no flush: `out_valid`←0, `taken`←0, `illegal`←0 (bubble).
- `stall`=1, `flush`=0: all outputs and counters hold; `in_valid` ignored (upstream holds its op).
- `flush`=1: `out_valid`, `taken`, `illegal` ←0 regardless of `stall` or `in_valid`; flush wins over everything. Counters hold.
- Counters: on capture of a legal op, `branch_cnt`+=1; also `taken_cnt`+=1 if taken. Each saturates at 2^CNT_W−1 (no wrap).
- `clr_cnt`: both counters ←0 next edge; overrides an increment in the same cycle; honoured even when `stall`=1.
- Reset (any time, mid-operation included): all outputs 0 immediately, asynchronously.

## Timing

- Latency 1: op presented at edge N is reflected on outputs after edge N+1.
- Full throughput: one branch per cycle with no stall.
- Outputs purely registered; no combinational path from inputs to outputs.
- Reset deassertion: first capture on the first rising edge where `reset`=0.

## Structure

- Shared package `branch_pkg`: op encoding constants (`BR_BEQ`…`BR_BGEZ`), reserved-range check.
- Sub-module `branch_cond`: combinational, parametrised by `WIDTH`; inputs `op`, `rs_data`, `rt_data`; outputs `cond`, `reserved`. Top level holds output registers and counters.

## Test plan

- Reset: hold `reset`=1 mid-stream with `out_valid`=1 -> all outputs 0 without waiting for an edge.
- Conditions (WIDTH=32): bltz rs=0x8000_0000 -> taken=1; bgez rs=0 -> 1; bgtz rs=0 -> 0; blez rs=0 -> 1; beq 5,5 -> 1; bne 5,5 -> 0; each one cycle after presentation.
- Stall/flush: capture beq taken, then `stall`=1 for 3 cycles with new ops -> outputs frozen at taken=1; assert `flush`+`stall` together -> out_valid=0, taken=0 next edge.
- Reserved: op=6, in_valid=1 -> out_valid=1, illegal=1, taken=0; branch_cnt unchanged.
- Counters: CNT_W=4, 20 taken bltz ops -> branch_cnt=taken_cnt=15 (saturated); `clr_cnt` with simultaneous capture -> both 0.
- Width: WIDTH=8, bltz rs=0x80 -> 1, bgtz rs=0x7F -> 1, rs=0xFF blez -> 1.
